// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the matching scanner.
// Holds the key layout, the state encoding and the bounce LFSR step function.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    GAP
  } emu_state_t;

  // Row-major layout, index = row*4 + col.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Returns {row[1:0], col[1:0]} of the switch that produces the given hex code.
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    rc = '0;
    for (int i = 0; i < 16; i++) begin
      if (KEY_MAP[i] == code) begin
        rc = 4'(i);
      end
    end
    return rc;
  endfunction

  // Fibonacci step for x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/keypad_emulator_lfsr.sv
// 8-bit pseudo-random chatter source for contact bounce.
// Advances one step per enabled cycle; an all-zero seed would lock up, so it becomes 1.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic       rnd
);

  logic [7:0] q;
  logic [7:0] seed_safe;

  assign seed_safe = (seed == 8'h00) ? 8'h01 : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed_safe;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

  assign rnd = q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Switch-matrix side of a 4x4 keypad: accepts a hex key and closes that switch
// through a press-bounce / hold / release-bounce / gap profile.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = 64,
  parameter int         HOLD_CYCLES   = 2000,
  parameter int         GAP_CYCLES    = 500,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       bounce_en,
  input  logic [3:0] col_keys,
  output logic [3:0] row_keys,
  output logic       busy,
  output logic       done
);

  localparam int BOUNCE_LEN = (BOUNCE_CYCLES < 1) ? 1 : BOUNCE_CYCLES;
  localparam int HOLD_LEN   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_LEN    = (GAP_CYCLES    < 1) ? 1 : GAP_CYCLES;
  localparam int MAX_LEN    = (BOUNCE_LEN > HOLD_LEN)
                              ? ((BOUNCE_LEN > GAP_LEN) ? BOUNCE_LEN : GAP_LEN)
                              : ((HOLD_LEN > GAP_LEN) ? HOLD_LEN : GAP_LEN);
  localparam int CNT_W      = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  emu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       row_sel, col_sel;
  logic             contact, contact_next;
  logic             accept;
  logic             lfsr_en;
  logic             rnd;
  logic [3:0]       rc;

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == GAP) && (cnt == '0);
  assign accept    = key_valid && key_ready;
  assign rc        = key_to_rc(key_code);

  bounce_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .rnd  (rnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      contact <= 1'b0;
      row_sel <= 2'd0;
      col_sel <= 2'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      contact <= contact_next;
      if (accept) begin
        row_sel <= rc[3:2];
        col_sel <= rc[1:0];
      end
    end
  end

  // Sequencing: each phase loads its length-1 and leaves on the cycle the counter reads zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = PRESS_BOUNCE;
          cnt_next   = BOUNCE_LOAD;
        end
      end
      PRESS_BOUNCE: begin
        if (cnt == '0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = RELEASE_BOUNCE;
          cnt_next   = BOUNCE_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      RELEASE_BOUNCE: begin
        if (cnt == '0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Contact is registered for the upcoming cycle; every bounce cycle consumes one LFSR bit,
  // and the last cycle of each bounce phase settles to the phase's final level.
  always_comb begin
    contact_next = 1'b0;
    lfsr_en      = 1'b0;
    case (state_next)
      PRESS_BOUNCE: begin
        lfsr_en      = 1'b1;
        contact_next = (cnt_next == '0) || !bounce_en || rnd;
      end
      HOLD: begin
        contact_next = 1'b1;
      end
      RELEASE_BOUNCE: begin
        lfsr_en      = 1'b1;
        contact_next = (cnt_next != '0) && bounce_en && rnd;
      end
      default: begin
        contact_next = 1'b0;
      end
    endcase
  end

  // Real switch behaviour: the selected row follows the scanner's column drive with no delay.
  always_comb begin
    row_keys = 4'b0000;
    if (contact && col_keys[col_sel]) begin
      row_keys[row_sel] = 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: a cycle model queues expected outputs at each
// rising edge and a monitor compares them against the DUT at the following falling edge.
module tb_keypad_emulator;

  localparam int         B     = 6;
  localparam int         H     = 20;
  localparam int         G     = 8;
  localparam int         TOTAL = 2 * B + H + G;
  localparam logic [7:0] SEED  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       bounce_en;
  logic [3:0] col_keys;
  logic       key_ready;
  logic [3:0] row_keys;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  keypad_emulator #(
    .BOUNCE_CYCLES (B),
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .bounce_en (bounce_en),
    .col_keys  (col_keys),
    .row_keys  (row_keys),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic       contact;
    logic [1:0] row;
    logic [1:0] col;
    logic       ready;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;

  int         mk;
  logic [7:0] mlfsr;
  logic [3:0] mrc;
  logic       mbit;
  exp_t       mexp;
  exp_t       cexp;
  logic [3:0] exp_row;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] m);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  endfunction

  function automatic logic [3:0] model_rc(input logic [3:0] code);
    logic [3:0] tbl [16];
    logic [3:0] rc;
    tbl = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    rc = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] == code) rc = 4'(i);
    end
    return rc;
  endfunction

  // Model: mk counts cycles since accept (1 = first press-bounce cycle, 0 = idle).
  initial begin
    mk    = 0;
    mlfsr = SEED;
    mrc   = 4'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mk    = 0;
        mlfsr = SEED;
      end else if (mk == 0) begin
        if (key_valid) begin
          mk  = 1;
          mrc = model_rc(key_code);
        end
      end else if (mk == TOTAL) begin
        mk = 0;
      end else begin
        mk++;
      end
      mexp.contact = 1'b0;
      if (mk >= 1 && mk <= B) begin
        mbit  = mlfsr[0];
        mlfsr = model_step(mlfsr);
        mexp.contact = (mk == B) ? 1'b1 : (bounce_en ? mbit : 1'b1);
      end else if (mk > B && mk <= B + H) begin
        mexp.contact = 1'b1;
      end else if (mk > B + H && mk <= 2 * B + H) begin
        mbit  = mlfsr[0];
        mlfsr = model_step(mlfsr);
        mexp.contact = (mk == 2 * B + H) ? 1'b0 : (bounce_en ? mbit : 1'b0);
      end
      mexp.row   = mrc[3:2];
      mexp.col   = mrc[1:0];
      mexp.ready = (mk == 0);
      mexp.busy  = (mk != 0);
      mexp.done  = (mk == TOTAL);
      sb.push_back(mexp);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        cexp    = sb.pop_front();
        exp_row = (cexp.contact && col_keys[cexp.col]) ? 4'(4'b0001 << cexp.row) : 4'b0000;
        checkOutput("row_keys", 32'(row_keys), 32'(exp_row));
        checkOutput("key_ready", 32'(key_ready), 32'(cexp.ready));
        checkOutput("busy", 32'(busy), 32'(cexp.busy));
        checkOutput("done", 32'(done), 32'(cexp.done));
      end
    end
  end

  task automatic applyStimulus(input logic valid, input logic [3:0] code,
                               input logic ben, input logic [3:0] col);
    key_valid = valid;
    key_code  = code;
    bounce_en = ben;
    col_keys  = col;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < budget) begin
      stepCycles(1);
      n++;
    end
    checkOutput("ready_wait", 32'(key_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 4'b0100);
    stepCycles(2);
    rst = 1'b0;
    stepCycles(2);

    // Key 6, clean edges, scanner rotating its column drive.
    applyStimulus(1'b1, 4'h6, 1'b0, 4'b0001);
    stepCycles(1);
    key_valid = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) begin
      col_keys = 4'(4'b0001 << (i % 4));
      stepCycles(1);
    end
    waitReady(20);

    // Key C with chatter on a fixed column.
    applyStimulus(1'b1, 4'hC, 1'b1, 4'b1000);
    stepCycles(1);
    key_valid = 1'b0;
    stepCycles(TOTAL + 2);
    waitReady(20);

    // Key 3 requested continuously: second accept exactly when ready returns.
    applyStimulus(1'b1, 4'h3, 1'b1, 4'b0100);
    stepCycles(TOTAL + 2);
    key_valid = 1'b0;
    stepCycles(TOTAL + 2);
    waitReady(20);

    // Key 0, reset in the middle of the hold phase.
    applyStimulus(1'b1, 4'h0, 1'b0, 4'b0010);
    stepCycles(1);
    key_valid = 1'b0;
    stepCycles(B + 6);
    rst = 1'b1;
    stepCycles(1);
    rst = 1'b0;
    stepCycles(3);

    // Key A with random column drive and bounce_en toggling mid-phase.
    applyStimulus(1'b1, 4'hA, 1'b1, 4'b1000);
    stepCycles(1);
    key_valid = 1'b0;
    for (int i = 0; i < TOTAL + 3; i++) begin
      col_keys  = 4'($urandom_range(0, 15));
      bounce_en = 1'($urandom_range(0, 1));
      stepCycles(1);
    end
    waitReady(20);
    stepCycles(2);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
